signed_seq_div: RTL and testbench
=================================

// Module: signed_seq_div
// PURPOSE
//  Sequential signed divider: the inverse of the signed sequential multiplier. Takes a
//  sign-magnitude dividend (multiplier product format) and an 8-bit two's-complement divisor.
//  Returns quotient and remainder magnitudes plus their signs, using restoring division at
//  one bit per clock. Sits beside the multiplier in the arithmetic datapath.
// PARAMETERS
//  N_DVD   15  dividend/quotient magnitude width (matches multiplier product width)
//  N_DVS   8   divisor width, two's complement; remainder magnitude width
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  divide_but     in   1      start pulse/level; sampled only in IDLE or DONE
//  dividend_mag   in   N_DVD  dividend magnitude
//  dividend_sign  in   1      dividend sign (1 = negative)
//  divisor        in   N_DVS  signed divisor, two's complement
//  quotient       out  N_DVD  |quotient|; reads 0 unless done=1
//  remainder      out  N_DVS  |remainder|; reads 0 unless done=1
//  q_sign         out  1      quotient sign, registered
//  r_sign         out  1      remainder sign, registered
//  done           out  1      result valid; held until next accepted start
//  div_by_zero    out  1      divisor was 0 for the current result
// BEHAVIOUR
//  Reset (rst_n=0, any time, incl. mid-CALC): state=IDLE; count=0; all internal regs and all
//   outputs = 0.
//  FSM: IDLE -> CALC on divide_but=1 (divisor!=0); IDLE -> DONE on divide_but=1
//   (divisor==0); CALC -> DONE when count==N_DVD-1; DONE -> CALC/DONE on divide_but=1 as
//   from IDLE; DONE otherwise holds.
//  Start edge: latch dividend_mag into dvd shift reg, |divisor| into dvs reg (N_DVS+1 bits
//   internally so -128 -> 128 is exact), rem=0, quo=0, count=0. Latch
//   q_sign = dividend_sign ^ divisor[N_DVS-1] and r_sign = dividend_sign.
//  divide_but is ignored while in CALC (no restart, no abort).
//  CALC, each edge: t = {rem, dvd[MSB]}; dvd <<= 1; if t >= dvs then rem = t - dvs and
//   shift quo in 1, else rem = t and shift quo in 0; count++.
//  Latency: start accepted at edge k -> done=1 after edge k+N_DVD (k+15).
//   Divide-by-zero: done=1 after edge k+1.
//  Divide-by-zero: quotient=0, remainder=0, q_sign=r_sign=0, div_by_zero=1.
//   div_by_zero clears on the next accepted start.
//  Zero results: sign forced to 0 (q_sign=0 if quotient==0; r_sign=0 if remainder==0),
//   evaluated on the CALC->DONE transition.
//  Truncating division: remainder takes the dividend's sign; |remainder| < |divisor| <= 128,
//   so it fits N_DVS bits.
//  Width rule: rem datapath N_DVS+1 bits; comparison and subtraction are unsigned at
//   N_DVS+1 bits.
//  Inputs are sampled only on the start edge; changes while in CALC have no effect.
//  Start while done=1: done drops after that edge; outputs read 0 until the new result.
// STRUCTURE
//  Package signed_div_pkg: state enum {IDLE, CALC, DONE}; N_DVD/N_DVS defaults;
//   CNT_W = $clog2(N_DVD).
//  Sub-module div_step (combinational): in rem, next dvd bit, dvs; out new rem, quotient bit.
//   Top holds FSM, counter, shift regs, sign logic, output gating.
// TESTING
//  1. 100 (+) / 7 -> done at k+15; quotient=14, remainder=2, q_sign=0, r_sign=0.
//  2. 100 (-) / 8'hF9 (-7) -> quotient=14, q_sign=0; remainder=2, r_sign=1.
//     100 (+) / -7 -> q_sign=1, r_sign=0.
//  3. 16384 (+) / 8'h80 (-128) -> quotient=128, q_sign=1, remainder=0, r_sign=0.
//     32767 / 1 -> quotient=32767, remainder=0.
//  4. 5 (-) / 0 -> done at k+1; div_by_zero=1, quotient=0, remainder=0, signs=0.
//     Next start with 9/3 -> div_by_zero=0, quotient=3.
//  5. 3 (-) / 10 -> quotient=0, q_sign=0 (forced); remainder=3, r_sign=1.
//  6. Assert rst_n=0 at CALC cycle 6 -> outputs 0 immediately (async), state IDLE.
//     divide_but pulsed during CALC -> ignored; result and latency unchanged.

Source files
------------

// File: rtl/signed_seq_div_pkg.sv
// signed_div_pkg: shared widths, FSM state type and divisor magnitude helper
package signed_div_pkg;
  localparam int N_DVD = 15;
  localparam int N_DVS = 8;
  localparam int CNT_W = $clog2(N_DVD);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  // One extra bit so that -128 becomes an exact 128
  function automatic logic [N_DVS:0] abs_dvs(input logic [N_DVS-1:0] d);
    logic [N_DVS:0] e;
    e = {d[N_DVS-1], d};
    return e[N_DVS] ? -e : e;
  endfunction
endpackage

// File: rtl/signed_seq_div_if.sv
// signed_seq_div_if: start/operand and result bundle of the sequential divider
interface signed_seq_div_if;
  import signed_div_pkg::*;
  logic             divide_but;
  logic [N_DVD-1:0] dividend_mag;
  logic             dividend_sign;
  logic [N_DVS-1:0] divisor;
  logic [N_DVD-1:0] quotient;
  logic [N_DVS-1:0] remainder;
  logic             q_sign;
  logic             r_sign;
  logic             done;
  logic             div_by_zero;
  modport master(output divide_but, dividend_mag, dividend_sign, divisor,
                 input quotient, remainder, q_sign, r_sign, done, div_by_zero);
  modport slave(input divide_but, dividend_mag, dividend_sign, divisor,
                output quotient, remainder, q_sign, r_sign, done, div_by_zero);
endinterface

// File: rtl/signed_seq_div_step.sv
// div_step: one restoring-division step on magnitudes
module div_step
  import signed_div_pkg::*;
(
  input  logic [N_DVS:0] rem,
  input  logic           bit_in,
  input  logic [N_DVS:0] dvs,
  output logic [N_DVS:0] rem_next,
  output logic           q_bit
);
  localparam int W = N_DVS + 1;
  logic [N_DVS+1:0] t;
  assign t        = {rem, bit_in};
  assign q_bit    = t >= {1'b0, dvs};
  assign rem_next = q_bit ? W'(t - {1'b0, dvs}) : t[N_DVS:0];
endmodule

// File: rtl/signed_seq_div.sv
// signed_seq_div: sign-magnitude / two's-complement restoring divider, one bit per clock
module signed_seq_div
  import signed_div_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  signed_seq_div_if.slave bus
);
  state_t           state;
  logic [CNT_W-1:0] count;
  logic [N_DVD-1:0] dvd, quo, quo_nx;
  logic [N_DVS:0]   dvs, rem, rem_nx;
  logic             q_sign_r, r_sign_r, done_r, dbz, q_bit, start, zero_dvs;

  div_step u_step (.rem(rem), .bit_in(dvd[N_DVD-1]), .dvs(dvs), .rem_next(rem_nx), .q_bit(q_bit));

  assign quo_nx   = {quo[N_DVD-2:0], q_bit};
  assign start    = bus.divide_but && state != CALC;
  assign zero_dvs = bus.divisor == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      q_sign_r <= 1'b0;
      r_sign_r <= 1'b0;
      done_r   <= 1'b0;
      dbz      <= 1'b0;
    end else if (start) begin
      state    <= zero_dvs ? DONE : CALC;
      count    <= '0;
      dvd      <= bus.dividend_mag;
      dvs      <= abs_dvs(bus.divisor);
      rem      <= '0;
      quo      <= '0;
      q_sign_r <= !zero_dvs && (bus.dividend_sign ^ bus.divisor[N_DVS-1]);
      r_sign_r <= !zero_dvs && bus.dividend_sign;
      done_r   <= 1'b0;
      dbz      <= zero_dvs;
    end else if (state == CALC) begin
      dvd   <= dvd << 1;
      rem   <= rem_nx;
      quo   <= quo_nx;
      count <= count + 1'b1;
      // Last step: publish the result and drop signs of zero magnitudes
      if (count == CNT_W'(N_DVD - 1)) begin
        state    <= DONE;
        done_r   <= 1'b1;
        q_sign_r <= q_sign_r && quo_nx != '0;
        r_sign_r <= r_sign_r && rem_nx != '0;
      end
    end else if (state == DONE) begin
      done_r <= 1'b1;
    end
  end

  assign bus.quotient    = done_r ? quo : '0;
  assign bus.remainder   = done_r ? rem[N_DVS-1:0] : '0;
  assign bus.q_sign      = q_sign_r;
  assign bus.r_sign      = r_sign_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_signed_seq_div.sv
// tb_signed_seq_div: directed checks of the sequential signed divider
module tb_signed_seq_div;
  import signed_div_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;

  signed_seq_div_if bus();
  signed_seq_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
  endtask

  // Drive operands and a one-edge start pulse; returns #1 after the accepting edge
  task automatic start(input int mag, input bit sgn, input logic [7:0] dv);
    @(negedge clk);
    bus.dividend_mag  = 15'(mag);
    bus.dividend_sign = sgn;
    bus.divisor       = dv;
    bus.divide_but    = 1'b1;
    @(posedge clk);
    #1 bus.divide_but = 1'b0;
  endtask

  // Checks done is low one edge before the expected latency and high at it
  task automatic wait_done(input string tag, input int lat);
    repeat (lat - 1) @(posedge clk);
    #1 chk({tag, "_early"}, int'(bus.done), 0);
    chk({tag, "_q_gated"}, int'(bus.quotient), 0);
    @(posedge clk);
    #1 chk({tag, "_done"}, int'(bus.done), 1);
  endtask

  task automatic chk_res(input string tag, input int q, input int qs, input int r, input int rs);
    chk({tag, "_quo"}, int'(bus.quotient), q);
    chk({tag, "_qs"}, int'(bus.q_sign), qs);
    chk({tag, "_rem"}, int'(bus.remainder), r);
    chk({tag, "_rs"}, int'(bus.r_sign), rs);
  endtask

  initial begin
    bus.divide_but = 1'b0;
    bus.dividend_mag = '0;
    bus.dividend_sign = 1'b0;
    bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1 chk("rst_done", int'(bus.done), 0);
    chk_res("rst", 0, 0, 0, 0);
    chk("rst_dbz", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;

    start(100, 0, 8'd7);
    wait_done("p7", 15);
    chk_res("p7", 14, 0, 2, 0);
    chk("p7_dbz", int'(bus.div_by_zero), 0);

    start(100, 1, 8'hF9);
    wait_done("nn7", 15);
    chk_res("nn7", 14, 0, 2, 1);

    start(100, 0, 8'hF9);
    wait_done("pn7", 15);
    chk_res("pn7", 14, 1, 2, 0);

    start(16384, 0, 8'h80);
    wait_done("m128", 15);
    chk_res("m128", 128, 1, 0, 0);

    start(32767, 0, 8'd1);
    wait_done("max1", 15);
    chk_res("max1", 32767, 0, 0, 0);

    start(5, 1, 8'd0);
    chk("dz_drop", int'(bus.done), 0);
    @(posedge clk);
    #1 chk("dz_done", int'(bus.done), 1);
    chk("dz_flag", int'(bus.div_by_zero), 1);
    chk_res("dz", 0, 0, 0, 0);

    start(9, 0, 8'd3);
    chk("d93_dbz_clr", int'(bus.div_by_zero), 0);
    wait_done("d93", 15);
    chk_res("d93", 3, 0, 0, 0);

    start(3, 1, 8'd10);
    wait_done("small", 15);
    chk_res("small", 0, 0, 3, 1);

    start(100, 1, 8'd7);
    repeat (6) @(posedge clk);
    #1 chk("mid_qs_pre", int'(bus.q_sign), 1);
    chk("mid_state_pre", int'(dut.state), int'(CALC));
    rst_n = 1'b0;
    #1 chk("mid_rst_qs", int'(bus.q_sign), 0);
    chk("mid_rst_rs", int'(bus.r_sign), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_state", int'(dut.state), int'(IDLE));
    chk("mid_rst_cnt", int'(dut.count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    start(100, 0, 8'd7);
    repeat (5) @(posedge clk);
    #1 bus.divide_but = 1'b1;
    bus.dividend_mag = 15'd200;
    bus.divisor = 8'd3;
    bus.dividend_sign = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.divide_but = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("ign_early", int'(bus.done), 0);
    @(posedge clk);
    #1 chk("ign_done", int'(bus.done), 1);
    chk_res("ign", 14, 0, 2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
